// File: rtl/ir_pkg.sv
// Shared types and mode encodings for the chunked instruction register.
package ir_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} ir_state_e;
  localparam logic IR_MODE_ADDR = 1'b0;
  localparam logic IR_MODE_SEQ  = 1'b1;
endpackage

// File: rtl/ir_chunk_buffer.sv
// One chunk buffer: data, written-mask and sequential pointer, with clear/restart/transfer.
// The o_nxt_* outputs show the state after this cycle's write only, so a peer buffer can take them.
module ir_chunk_buffer
  import ir_pkg::*;
#(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 2,
  localparam int SEL_W     = $clog2(NUM_CHUNKS)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_clear,
  input  logic                                i_restart,
  input  logic                                i_xfer,
  input  logic                                i_wr,
  input  logic                                i_mode,
  input  logic [SEL_W-1:0]                    i_sel,
  input  logic [CHUNK_W-1:0]                  i_data,
  input  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  i_xfer_data,
  input  logic [NUM_CHUNKS-1:0]               i_xfer_mask,
  input  logic [SEL_W-1:0]                    i_xfer_ptr,
  output logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  o_data,
  output logic [NUM_CHUNKS-1:0]               o_mask,
  output logic [SEL_W-1:0]                    o_ptr,
  output logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  o_nxt_data,
  output logic [NUM_CHUNKS-1:0]               o_nxt_mask,
  output logic [SEL_W-1:0]                    o_nxt_ptr,
  output logic                                o_complete
);
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] r_data;
  logic [NUM_CHUNKS-1:0]              r_mask;
  logic [SEL_W-1:0]                   r_ptr;
  logic [SEL_W-1:0]                   w_idx;

  always_comb begin
    w_idx      = (i_mode == IR_MODE_SEQ) ? r_ptr : i_sel;
    o_nxt_data = r_data;
    o_nxt_mask = r_mask;
    o_nxt_ptr  = r_ptr;
    if (i_wr && (32'(w_idx) < NUM_CHUNKS)) begin
      o_nxt_data[w_idx] = i_data;
      o_nxt_mask[w_idx] = 1'b1;
    end
    if (i_wr && (i_mode == IR_MODE_SEQ))
      o_nxt_ptr = (32'(r_ptr) == NUM_CHUNKS - 1) ? '0 : r_ptr + SEL_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_mask <= '0;
      r_ptr  <= '0;
    end else if (i_clear) begin
      r_data <= '0;
      r_mask <= '0;
      r_ptr  <= '0;
    end else if (i_xfer) begin
      // Only written chunks move; unwritten ones keep the previous instruction's bytes.
      for (int k = 0; k < NUM_CHUNKS; k++)
        if (i_xfer_mask[k]) r_data[k] <= i_xfer_data[k];
      r_mask <= i_xfer_mask;
      r_ptr  <= i_xfer_ptr;
    end else if (i_restart) begin
      r_mask <= '0;
      r_ptr  <= '0;
    end else begin
      r_data <= o_nxt_data;
      r_mask <= o_nxt_mask;
      r_ptr  <= o_nxt_ptr;
    end
  end

  assign o_data     = r_data;
  assign o_mask     = r_mask;
  assign o_ptr      = r_ptr;
  assign o_complete = &r_mask;
endmodule

// File: rtl/chunked_instruction_register.sv
// Assembles an IR_W-bit instruction from CHUNK_W-bit transfers, handed off via valid/consume.
// Define IR_PREFETCH_EN to add a shadow buffer that accepts writes while the main one is full.
module chunked_instruction_register
  import ir_pkg::*;
#(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 2,
  localparam int SEL_W     = $clog2(NUM_CHUNKS),
  localparam int IR_W      = CHUNK_W * NUM_CHUNKS
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [CHUNK_W-1:0] i_data,
  input  logic               i_write,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic               i_mode,
  input  logic               i_clear,
  input  logic               i_consume,
  output logic [IR_W-1:0]    o_ir_out,
  output logic               o_valid,
  output logic [SEL_W-1:0]   o_chunk_ptr,
  output logic               o_overrun
);
  ir_state_e r_state;
  logic      r_valid, r_overrun;

  logic w_full, w_consume, w_drop, w_main_wr, w_main_xfer, w_main_restart;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] w_main_data, w_main_nxt_data, w_xfer_data;
  logic [NUM_CHUNKS-1:0]              w_main_mask, w_main_nxt_mask, w_xfer_mask, w_next_mask;
  logic [SEL_W-1:0]                   w_main_ptr, w_main_nxt_ptr, w_xfer_ptr;
  logic                               w_main_complete;

  assign w_full    = (r_state == FULL);
  assign w_consume = i_consume && w_full;
  assign w_main_wr = i_write && !w_full;

  ir_chunk_buffer #(.CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS)) u_main (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_restart(w_main_restart),
    .i_xfer(w_main_xfer), .i_wr(w_main_wr), .i_mode(i_mode), .i_sel(i_sel), .i_data(i_data),
    .i_xfer_data(w_xfer_data), .i_xfer_mask(w_xfer_mask), .i_xfer_ptr(w_xfer_ptr),
    .o_data(w_main_data), .o_mask(w_main_mask), .o_ptr(w_main_ptr),
    .o_nxt_data(w_main_nxt_data), .o_nxt_mask(w_main_nxt_mask), .o_nxt_ptr(w_main_nxt_ptr),
    .o_complete(w_main_complete)
  );

`ifdef IR_PREFETCH_EN
  logic w_sh_wr, w_sh_complete;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] w_sh_data;
  logic [NUM_CHUNKS-1:0]              w_sh_mask;
  logic [SEL_W-1:0]                   w_sh_ptr;

  // A full shadow still takes a write in the consume cycle; it lands in main via the transfer.
  assign w_sh_wr = i_write && w_full && (!w_sh_complete || w_consume);
  assign w_drop  = i_write && w_full && w_sh_complete && !w_consume;

  ir_chunk_buffer #(.CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS)) u_shadow (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_restart(w_consume),
    .i_xfer(1'b0), .i_wr(w_sh_wr), .i_mode(i_mode), .i_sel(i_sel), .i_data(i_data),
    .i_xfer_data('0), .i_xfer_mask('0), .i_xfer_ptr('0),
    .o_data(w_sh_data), .o_mask(w_sh_mask), .o_ptr(w_sh_ptr),
    .o_nxt_data(w_xfer_data), .o_nxt_mask(w_xfer_mask), .o_nxt_ptr(w_xfer_ptr),
    .o_complete(w_sh_complete)
  );

  assign w_main_xfer    = w_consume;
  assign w_main_restart = 1'b0;
  assign w_next_mask    = w_consume ? w_xfer_mask : w_main_nxt_mask;

  logic w_unused;
  assign w_unused = ^{w_main_mask, w_main_nxt_data, w_main_nxt_ptr, w_main_complete,
                      w_sh_data, w_sh_mask, w_sh_ptr};
`else
  assign w_drop         = i_write && w_full;
  assign w_main_xfer    = 1'b0;
  assign w_main_restart = w_consume;
  assign w_xfer_data    = '0;
  assign w_xfer_mask    = '0;
  assign w_xfer_ptr     = '0;
  assign w_next_mask    = w_consume ? '0 : w_main_nxt_mask;

  logic w_unused;
  assign w_unused = ^{w_main_mask, w_main_nxt_data, w_main_nxt_ptr, w_main_complete};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= EMPTY;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_clear) begin
      r_state   <= EMPTY;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (&w_next_mask)      r_state <= FULL;
      else if (|w_next_mask) r_state <= FILLING;
      else                   r_state <= EMPTY;
      r_valid <= &w_next_mask;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign o_ir_out    = w_main_data;
  assign o_valid     = r_valid;
  assign o_chunk_ptr = w_main_ptr;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_chunked_instruction_register.sv
// Directed bench: a 2-chunk and a 4-chunk instance share stimulus; each step checks hand-computed values.
module tb_chunked_instruction_register;
  logic        clk = 1'b0;
  logic        rst, wr, mode, clr, cons;
  logic [7:0]  din;
  logic        sel2;
  logic [1:0]  sel4;
  logic [15:0] ir2;
  logic        v2, ov2, p2;
  logic [31:0] ir4;
  logic        v4, ov4;
  logic [1:0]  p4;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chunked_instruction_register #(.CHUNK_W(8), .NUM_CHUNKS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_write(wr), .i_sel(sel2), .i_mode(mode),
    .i_clear(clr), .i_consume(cons), .o_ir_out(ir2), .o_valid(v2), .o_chunk_ptr(p2),
    .o_overrun(ov2)
  );

  chunked_instruction_register #(.CHUNK_W(8), .NUM_CHUNKS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_write(wr), .i_sel(sel4), .i_mode(mode),
    .i_clear(clr), .i_consume(cons), .o_ir_out(ir4), .o_valid(v4), .o_chunk_ptr(p4),
    .o_overrun(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; mode = 1'b0; clr = 1'b0; cons = 1'b0;
    din = 8'h00; sel2 = 1'b0; sel4 = 2'd0;
    #12 rst = 1'b0;
    tick;
    chk("reset_ir", 32'(ir2), 32'h0);
    chk("reset_valid", 32'(v2), 32'h0);

    // 1: async reset mid-cycle discards a partial fill immediately
    mode = 1'b1; din = 8'h99; wr = 1'b1; tick; wr = 1'b0;
    chk("pre_rst_ir", 32'(ir2), 32'h0099);
    chk("pre_rst_ptr", 32'(p2), 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("rst_ir", 32'(ir2), 32'h0);
    chk("rst_valid", 32'(v2), 32'h0);
    chk("rst_ptr", 32'(p2), 32'h0);
    chk("rst_ovr", 32'(ov2), 32'h0);
    #2 rst = 1'b0;
    tick;

    // 2: addressed fill, high chunk first
    mode = 1'b0; sel2 = 1'b1; din = 8'h12; wr = 1'b1; tick; wr = 1'b0;
    chk("addr1_ir", 32'(ir2), 32'h1200);
    chk("addr1_valid", 32'(v2), 32'h0);
    sel2 = 1'b0; din = 8'h34; wr = 1'b1; tick; wr = 1'b0;
    chk("addr2_ir", 32'(ir2), 32'h1234);
    chk("addr2_valid", 32'(v2), 32'h1);
    chk("addr2_ptr", 32'(p2), 32'h0);

`ifndef IR_PREFETCH_EN
    // 4: write while full is dropped and sets overrun; clear wipes everything
    din = 8'h55; wr = 1'b1; tick; wr = 1'b0;
    chk("full_wr_ir", 32'(ir2), 32'h1234);
    chk("full_wr_ovr", 32'(ov2), 32'h1);
    chk("full_wr_valid", 32'(v2), 32'h1);
    din = 8'h66; wr = 1'b1; cons = 1'b1; tick; wr = 1'b0; cons = 1'b0;
    chk("wr_cons_valid", 32'(v2), 32'h0);
    chk("wr_cons_ir", 32'(ir2), 32'h1234);
    chk("wr_cons_ovr", 32'(ov2), 32'h1);
    clr = 1'b1; tick; clr = 1'b0;
    chk("clr_ir", 32'(ir2), 32'h0);
    chk("clr_ovr", 32'(ov2), 32'h0);
    chk("clr_valid", 32'(v2), 32'h0);
`else
    // 5: prefetch into shadow while full, consume promotes it
    mode = 1'b1; din = 8'h78; wr = 1'b1; tick;
    din = 8'h56; tick; wr = 1'b0;
    chk("pf_hold_ir", 32'(ir2), 32'h1234);
    chk("pf_hold_ovr", 32'(ov2), 32'h0);
    chk("pf_hold_valid", 32'(v2), 32'h1);
    cons = 1'b1; tick; cons = 1'b0;
    chk("pf_cons_ir", 32'(ir2), 32'h5678);
    chk("pf_cons_valid", 32'(v2), 32'h1);
    chk("pf_cons_ptr", 32'(p2), 32'h0);
    clr = 1'b1; tick; clr = 1'b0;
    chk("clr_ir", 32'(ir2), 32'h0);
    chk("clr_valid", 32'(v2), 32'h0);
`endif

    // Consume while not valid is ignored; sequential wrap
    mode = 1'b1; din = 8'hAA; wr = 1'b1; tick; wr = 1'b0;
    chk("seq1_ir", 32'(ir2), 32'h00AA);
    chk("seq1_ptr", 32'(p2), 32'h1);
    cons = 1'b1; tick; cons = 1'b0;
    chk("cons_ign_ptr", 32'(p2), 32'h1);
    chk("cons_ign_valid", 32'(v2), 32'h0);
    din = 8'hBB; wr = 1'b1; tick; wr = 1'b0;
    chk("seq2_ir", 32'(ir2), 32'hBBAA);
    chk("seq2_valid", 32'(v2), 32'h1);
    chk("seq2_ptr", 32'(p2), 32'h0);
    cons = 1'b1; tick; cons = 1'b0;
    chk("cons_valid", 32'(v2), 32'h0);
    chk("cons_ir_hold", 32'(ir2), 32'hBBAA);

    // Rewrite of one chunk keeps mask; mode change mid-fill completes it
    mode = 1'b0; sel2 = 1'b1; din = 8'h11; wr = 1'b1; tick;
    din = 8'h22; tick; wr = 1'b0;
    chk("rewr_ir", 32'(ir2), 32'h22AA);
    chk("rewr_valid", 32'(v2), 32'h0);
    mode = 1'b1; din = 8'h33; wr = 1'b1; tick; wr = 1'b0;
    chk("mix_ir", 32'(ir2), 32'h2233);
    chk("mix_valid", 32'(v2), 32'h1);
    chk("mix_ptr", 32'(p2), 32'h1);

    // 6: clear coinciding with the second sequential write
    clr = 1'b1; tick; clr = 1'b0;
    mode = 1'b1; din = 8'hAB; wr = 1'b1; tick;
    chk("c6_ir1", 32'(ir2), 32'h00AB);
    din = 8'hCD; clr = 1'b1; tick; clr = 1'b0; wr = 1'b0;
    chk("c6_valid", 32'(v2), 32'h0);
    chk("c6_ir", 32'(ir2), 32'h0);
    chk("c6_ptr", 32'(p2), 32'h0);
    din = 8'hEE; wr = 1'b1; tick; wr = 1'b0;
    chk("c6_after_ir", 32'(ir2), 32'h00EE);
    chk("c6_after_ptr", 32'(p2), 32'h1);

    // 3: four-chunk sequential fill with pointer wrap
    clr = 1'b1; tick; clr = 1'b0;
    mode = 1'b1; wr = 1'b1;
    din = 8'hAA; tick;
    din = 8'hBB; tick;
    din = 8'hCC; tick;
    chk("n4_part_ir", ir4, 32'h00CCBBAA);
    chk("n4_part_valid", 32'(v4), 32'h0);
    chk("n4_part_ptr", 32'(p4), 32'h3);
    din = 8'hDD; tick; wr = 1'b0;
    chk("n4_ir", ir4, 32'hDDCCBBAA);
    chk("n4_valid", 32'(v4), 32'h1);
    chk("n4_ptr", 32'(p4), 32'h0);
    chk("n4_ovr", 32'(ov4), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
